// File: rtl/sys_ctrl_pkg.sv
// sys_ctrl_pkg: command codes, FSM states and field widths shared by the RX and TX controllers
package sys_ctrl_pkg;
  localparam logic [7:0] CMD_WR      = 8'hAA;
  localparam logic [7:0] CMD_RD      = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;
  localparam int ADDR_W = 4;
  localparam int FUN_W  = 4;
  typedef enum logic [3:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, ALU_A, ALU_B, ALU_FUNC, ALU_WAIT
  } state_t;
  function automatic logic is_alu(input state_t s);
    return s inside {ALU_A, ALU_B, ALU_FUNC, ALU_WAIT};
  endfunction
endpackage

// File: rtl/sys_ctrl_timeout.sv
// sys_ctrl_timeout: idle-cycle counter with clear input and expiry flag
module sys_ctrl_timeout #(
  parameter int TIMEOUT = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  output logic o_expired
);
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] r_cnt;
  assign o_expired = r_cnt == CW'(TIMEOUT);
  // count idle cycles; an expiry restarts the count since the frame is abandoned
  always_ff @(posedge clk)
    if (rst || i_clr || o_expired) r_cnt <= '0;
    else r_cnt <= r_cnt + 1'b1;
endmodule

// File: rtl/sys_ctrl_rx_cmd.sv
// sys_ctrl_rx_cmd: parses RX command frames into reg-file and ALU operations
module sys_ctrl_rx_cmd
  import sys_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = ADDR_W,
  parameter int FUN_WIDTH  = FUN_W,
  parameter int TIMEOUT    = 1023
) (
  input  logic                  CLK,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] RX_P_DATA,
  input  logic                  RX_D_VLD,
  input  logic                  Rd_data_valid,
  input  logic                  ALU_OUT_valid,
  output logic [ADDR_WIDTH-1:0] Address,
  output logic                  WrEn,
  output logic                  RdEn,
  output logic [DATA_WIDTH-1:0] WrData,
  output logic [FUN_WIDTH-1:0]  ALU_FUN,
  output logic                  ALU_EN,
  output logic                  CLK_GATE_EN,
  output logic                  Cmd_err
);
  state_t                r_state, w_next;
  logic                  w_wait, w_acc, w_expired;
  logic                  w_wr, w_rd, w_en, w_err;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_data;
  logic [FUN_WIDTH-1:0]  w_fun;
  assign w_wait = r_state inside {RD_WAIT, ALU_WAIT};
  assign w_acc  = RX_D_VLD && !w_wait;
  sys_ctrl_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk      (CLK),
    .rst      (rst),
    .i_clr    (w_acc || r_state == IDLE),
    .o_expired(w_expired)
  );
  // state register
  always_ff @(posedge CLK)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  // next state plus next values of the registered outputs
  always_comb begin
    w_next = r_state;
    w_wr   = 1'b0;
    w_rd   = 1'b0;
    w_en   = 1'b0;
    w_err  = 1'b0;
    w_addr = Address;
    w_data = WrData;
    w_fun  = ALU_FUN;
    case (r_state)
      IDLE: if (RX_D_VLD) begin
        w_next = RX_P_DATA == CMD_WR      ? WR_ADDR  :
                 RX_P_DATA == CMD_RD      ? RD_ADDR  :
                 RX_P_DATA == CMD_ALU_OP  ? ALU_A    :
                 RX_P_DATA == CMD_ALU_NOP ? ALU_FUNC : IDLE;
        w_err  = w_next == IDLE;
      end
      WR_ADDR: if (RX_D_VLD) begin
        w_next = WR_DATA;
        w_addr = RX_P_DATA[ADDR_WIDTH-1:0];
      end
      WR_DATA: if (RX_D_VLD) begin
        w_next = IDLE;
        w_data = RX_P_DATA;
        w_wr   = 1'b1;
      end
      RD_ADDR: if (RX_D_VLD) begin
        w_next = RD_WAIT;
        w_addr = RX_P_DATA[ADDR_WIDTH-1:0];
        w_rd   = 1'b1;
      end
      RD_WAIT: w_next = Rd_data_valid ? IDLE : RD_WAIT;
      ALU_A: if (RX_D_VLD) begin
        w_next = ALU_B;
        w_addr = '0;
        w_data = RX_P_DATA;
        w_wr   = 1'b1;
      end
      ALU_B: if (RX_D_VLD) begin
        w_next = ALU_FUNC;
        w_addr = ADDR_WIDTH'(1);
        w_data = RX_P_DATA;
        w_wr   = 1'b1;
      end
      ALU_FUNC: if (RX_D_VLD) begin
        w_next = ALU_WAIT;
        w_fun  = RX_P_DATA[FUN_WIDTH-1:0];
        w_en   = 1'b1;
      end
      ALU_WAIT: w_next = ALU_OUT_valid ? IDLE : ALU_WAIT;
      default: w_next = IDLE;
    endcase
    if (w_wait && RX_D_VLD) w_err = 1'b1;
    if (r_state != IDLE && !w_acc && w_next == r_state && w_expired) begin
      w_next = IDLE;
      w_err  = 1'b1;
    end
  end
  // registered outputs; address, data and function hold between commands
  always_ff @(posedge CLK)
    if (rst) begin
      Address     <= '0;
      WrData      <= '0;
      ALU_FUN     <= '0;
      WrEn        <= 1'b0;
      RdEn        <= 1'b0;
      ALU_EN      <= 1'b0;
      CLK_GATE_EN <= 1'b0;
      Cmd_err     <= 1'b0;
    end else begin
      Address     <= w_addr;
      WrData      <= w_data;
      ALU_FUN     <= w_fun;
      WrEn        <= w_wr;
      RdEn        <= w_rd;
      ALU_EN      <= w_en;
      CLK_GATE_EN <= is_alu(w_next);
      Cmd_err     <= w_err;
    end
endmodule

// File: tb/tb_sys_ctrl_rx_cmd.sv
// tb_sys_ctrl_rx_cmd: cycle-accurate vector table and timeout sequences with an expected-output queue
module tb_sys_ctrl_rx_cmd;
  localparam int TO = 16;
  logic       CLK = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] RX_P_DATA = '0;
  logic       RX_D_VLD = 1'b0;
  logic       Rd_data_valid = 1'b0;
  logic       ALU_OUT_valid = 1'b0;
  logic [3:0] Address;
  logic       WrEn, RdEn, ALU_EN, CLK_GATE_EN, Cmd_err;
  logic [7:0] WrData;
  logic [3:0] ALU_FUN;
  int checks = 0;
  int errors = 0;
  typedef struct packed {
    logic       r;
    logic       v;
    logic [7:0] d;
    logic       rv;
    logic       av;
    logic [3:0] a;
    logic [7:0] wd;
    logic [3:0] f;
    logic [4:0] st;
  } vec_t;
  vec_t         tbl[$];
  logic [20:0]  exp_q[$];
  sys_ctrl_rx_cmd #(.TIMEOUT(TO)) dut (
    .CLK          (CLK),
    .rst          (rst),
    .RX_P_DATA    (RX_P_DATA),
    .RX_D_VLD     (RX_D_VLD),
    .Rd_data_valid(Rd_data_valid),
    .ALU_OUT_valid(ALU_OUT_valid),
    .Address      (Address),
    .WrEn         (WrEn),
    .RdEn         (RdEn),
    .WrData       (WrData),
    .ALU_FUN      (ALU_FUN),
    .ALU_EN       (ALU_EN),
    .CLK_GATE_EN  (CLK_GATE_EN),
    .Cmd_err      (Cmd_err)
  );
  always #5 CLK = ~CLK;
  function automatic vec_t mk(input logic r, input logic v, input logic [7:0] d, input logic rv,
                              input logic av, input logic [3:0] a, input logic [7:0] wd,
                              input logic [3:0] f, input logic [4:0] st);
    return '{r: r, v: v, d: d, rv: rv, av: av, a: a, wd: wd, f: f, st: st};
  endfunction
  task automatic apply(input vec_t x, input string nm);
    logic [20:0] e, g;
    @(negedge CLK);
    rst = x.r;
    RX_D_VLD = x.v;
    RX_P_DATA = x.d;
    Rd_data_valid = x.rv;
    ALU_OUT_valid = x.av;
    exp_q.push_back({x.a, x.wd, x.f, x.st});
    @(posedge CLK);
    #1;
    e = exp_q.pop_front();
    g = {Address, WrData, ALU_FUN, WrEn, RdEn, ALU_EN, CLK_GATE_EN, Cmd_err};
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s: got A=%h D=%h F=%h we/re/en/gate/err=%b, expected A=%h D=%h F=%h we/re/en/gate/err=%b",
               nm, g[20:17], g[16:9], g[8:5], g[4:0], e[20:17], e[16:9], e[8:5], e[4:0]);
    end
  endtask
  initial begin
    // st = {WrEn, RdEn, ALU_EN, CLK_GATE_EN, Cmd_err}
    tbl.push_back(mk(1, 0, 8'h00, 0, 0, 4'h0, 8'h00, 4'h0, 5'b00000));
    tbl.push_back(mk(1, 0, 8'h00, 0, 0, 4'h0, 8'h00, 4'h0, 5'b00000));
    tbl.push_back(mk(0, 1, 8'hAA, 0, 0, 4'h0, 8'h00, 4'h0, 5'b00000));
    tbl.push_back(mk(0, 1, 8'h05, 0, 0, 4'h5, 8'h00, 4'h0, 5'b00000));
    tbl.push_back(mk(0, 1, 8'h3C, 0, 0, 4'h5, 8'h3C, 4'h0, 5'b10000));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 4'h5, 8'h3C, 4'h0, 5'b00000));
    tbl.push_back(mk(0, 1, 8'hBB, 0, 0, 4'h5, 8'h3C, 4'h0, 5'b00000));
    tbl.push_back(mk(0, 1, 8'h07, 0, 0, 4'h7, 8'h3C, 4'h0, 5'b01000));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 4'h7, 8'h3C, 4'h0, 5'b00000));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 4'h7, 8'h3C, 4'h0, 5'b00000));
    tbl.push_back(mk(0, 0, 8'h00, 1, 0, 4'h7, 8'h3C, 4'h0, 5'b00000));
    tbl.push_back(mk(0, 0, 8'h00, 1, 0, 4'h7, 8'h3C, 4'h0, 5'b00000));
    tbl.push_back(mk(0, 1, 8'h5A, 0, 0, 4'h7, 8'h3C, 4'h0, 5'b00001));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 4'h7, 8'h3C, 4'h0, 5'b00000));
    tbl.push_back(mk(0, 1, 8'hCC, 0, 0, 4'h7, 8'h3C, 4'h0, 5'b00010));
    tbl.push_back(mk(0, 1, 8'h12, 0, 0, 4'h0, 8'h12, 4'h0, 5'b10010));
    tbl.push_back(mk(0, 1, 8'h34, 0, 0, 4'h1, 8'h34, 4'h0, 5'b10010));
    tbl.push_back(mk(0, 1, 8'h02, 0, 0, 4'h1, 8'h34, 4'h2, 5'b00110));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 4'h1, 8'h34, 4'h2, 5'b00010));
    tbl.push_back(mk(0, 0, 8'h00, 0, 1, 4'h1, 8'h34, 4'h2, 5'b00000));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 4'h1, 8'h34, 4'h2, 5'b00000));
    tbl.push_back(mk(0, 1, 8'hDD, 0, 0, 4'h1, 8'h34, 4'h2, 5'b00010));
    tbl.push_back(mk(0, 1, 8'h03, 0, 0, 4'h1, 8'h34, 4'h3, 5'b00110));
    tbl.push_back(mk(0, 1, 8'h11, 0, 0, 4'h1, 8'h34, 4'h3, 5'b00011));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 4'h1, 8'h34, 4'h3, 5'b00010));
    tbl.push_back(mk(0, 1, 8'h22, 0, 1, 4'h1, 8'h34, 4'h3, 5'b00001));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 4'h1, 8'h34, 4'h3, 5'b00000));
    tbl.push_back(mk(0, 0, 8'h00, 0, 1, 4'h1, 8'h34, 4'h3, 5'b00000));
    tbl.push_back(mk(0, 1, 8'hCC, 0, 0, 4'h1, 8'h34, 4'h3, 5'b00010));
    tbl.push_back(mk(0, 1, 8'h55, 0, 0, 4'h0, 8'h55, 4'h3, 5'b10010));
    tbl.push_back(mk(1, 1, 8'h66, 0, 0, 4'h0, 8'h00, 4'h0, 5'b00000));
    tbl.push_back(mk(0, 1, 8'hAA, 0, 0, 4'h0, 8'h00, 4'h0, 5'b00000));
    tbl.push_back(mk(0, 1, 8'h01, 0, 0, 4'h1, 8'h00, 4'h0, 5'b00000));
    tbl.push_back(mk(0, 1, 8'hFF, 0, 0, 4'h1, 8'hFF, 4'h0, 5'b10000));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 4'h1, 8'hFF, 4'h0, 5'b00000));
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("row%0d", i));
    // write frame abandoned after TO idle cycles
    apply(mk(0, 1, 8'hAA, 0, 0, 4'h1, 8'hFF, 4'h0, 5'b00000), "wr_to_cmd");
    for (int i = 0; i < TO; i++) apply(mk(0, 0, 8'h00, 0, 0, 4'h1, 8'hFF, 4'h0, 5'b00000), $sformatf("wr_to_idle%0d", i));
    apply(mk(0, 0, 8'h00, 0, 0, 4'h1, 8'hFF, 4'h0, 5'b00001), "wr_to_err");
    apply(mk(0, 0, 8'h00, 0, 0, 4'h1, 8'hFF, 4'h0, 5'b00000), "wr_to_after");
    // a byte arriving after exactly TO idle cycles is still accepted
    apply(mk(0, 1, 8'hAA, 0, 0, 4'h1, 8'hFF, 4'h0, 5'b00000), "edge_cmd");
    for (int i = 0; i < TO; i++) apply(mk(0, 0, 8'h00, 0, 0, 4'h1, 8'hFF, 4'h0, 5'b00000), $sformatf("edge_idle%0d", i));
    apply(mk(0, 1, 8'h04, 0, 0, 4'h4, 8'hFF, 4'h0, 5'b00000), "edge_addr");
    apply(mk(0, 1, 8'h77, 0, 0, 4'h4, 8'h77, 4'h0, 5'b10000), "edge_data");
    // ALU frame timeout drops the clock-gate enable
    apply(mk(0, 1, 8'hCC, 0, 0, 4'h4, 8'h77, 4'h0, 5'b00010), "alu_to_cmd");
    for (int i = 0; i < TO; i++) apply(mk(0, 0, 8'h00, 0, 0, 4'h4, 8'h77, 4'h0, 5'b00010), $sformatf("alu_to_idle%0d", i));
    apply(mk(0, 0, 8'h00, 0, 0, 4'h4, 8'h77, 4'h0, 5'b00001), "alu_to_err");
    // read wait that never sees valid, then a late valid is ignored
    apply(mk(0, 1, 8'hBB, 0, 0, 4'h4, 8'h77, 4'h0, 5'b00000), "rd_to_cmd");
    apply(mk(0, 1, 8'h09, 0, 0, 4'h9, 8'h77, 4'h0, 5'b01000), "rd_to_addr");
    for (int i = 0; i < TO; i++) apply(mk(0, 0, 8'h00, 0, 0, 4'h9, 8'h77, 4'h0, 5'b00000), $sformatf("rd_to_idle%0d", i));
    apply(mk(0, 0, 8'h00, 0, 0, 4'h9, 8'h77, 4'h0, 5'b00001), "rd_to_err");
    apply(mk(0, 0, 8'h00, 1, 0, 4'h9, 8'h77, 4'h0, 5'b00000), "rd_late_valid");
    apply(mk(0, 1, 8'hBB, 0, 0, 4'h9, 8'h77, 4'h0, 5'b00000), "rd_again_cmd");
    apply(mk(0, 1, 8'h0E, 0, 0, 4'hE, 8'h77, 4'h0, 5'b01000), "rd_again_addr");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
